// File: rtl/fp_multiplier_param.sv
// Parametrised IEEE-754 multiplier: multi-cycle FSM, one operation in flight, valid/ready on both sides.
// Define FPMUL_DAZ_EN to treat subnormal inputs as zero and flush tiny results to zero.
module fp_multiplier_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset_ni,
    input  logic [EXP_W+MAN_W:0]   a_value_i,
    input  logic [EXP_W+MAN_W:0]   b_value_i,
    input  logic [1:0]             rm_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    output logic [EXP_W+MAN_W:0]   z_value_o,
    output logic [3:0]             flags_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i
);
    localparam int W  = EXP_W + MAN_W + 1;
    localparam int XW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic signed [XW-1:0] ONE  = XW'(1);
    localparam logic signed [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EMIN = ONE - BIAS;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [3:0] {
        IDLE, UNPACK, SPECIAL, NORM_A, NORM_B, MULTIPLY,
        NORMALIZE, DENORM, ROUND, PACK, DONE
    } state_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   rm;
    } req_t;

    typedef struct packed {
        logic [MAN_W:0] m;
        logic           zero;
        logic           inf;
        logic           nan;
        logic           snan;
    } opnd_t;

    function automatic opnd_t unpack_op(input logic [W-1:0] v);
        opnd_t o;
        logic [EXP_W-1:0] ef;
        logic [MAN_W-1:0] ff;
        ef     = v[W-2:MAN_W];
        ff     = v[MAN_W-1:0];
        o.nan  = (&ef) && (|ff);
        o.snan = o.nan && !ff[MAN_W-1];
        o.inf  = (&ef) && !(|ff);
`ifdef FPMUL_DAZ_EN
        o.zero = ~|ef;
`else
        o.zero = (~|ef) && (~|ff);
`endif
        o.m    = {|ef, ff};
        return o;
    endfunction

    // Subnormals carry the minimum exponent; NORM_A/NORM_B fix up the hidden bit.
    function automatic logic signed [XW-1:0] unpack_exp(input logic [W-1:0] v);
        logic [EXP_W-1:0] ef;
        ef = v[W-2:MAN_W];
        return (|ef) ? $signed({2'b00, ef}) - BIAS : EMIN;
    endfunction

    state_t state, state_d;
    logic   in_ready_d, out_valid_d;

    req_t                  req_q;
    opnd_t                 op_a, op_b;
    logic signed [XW-1:0]  ea_q, eb_q, exp_q;
    logic                  sign_q;
    logic [PW-1:0]         prod_q;
    logic [MAN_W:0]        mant_q;
    logic                  grd_q, rnd_q, stk_q, tiny_q, nx_q;
    logic                  spec_q, spec_nv;
    logic [W-1:0]          spec_z;

    logic                  is_special, spec_nv_d;
    logic [W-1:0]          spec_z_d;
    logic [PW-1:0]         pn;
    logic signed [XW-1:0]  e_norm;
    logic                  inc_d;
    logic [MAN_W+1:0]      sum;
    logic                  ovf, ovf_inf;
    logic [EXP_W-1:0]      efield;
    logic [W-1:0]          z_d;
    logic [3:0]            flags_d;

    always_ff @(posedge clk) begin
        if (!reset_ni) state <= IDLE;
        else           state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:      if (in_valid_i && in_ready_o) state_d = UNPACK;
            UNPACK:    state_d = SPECIAL;
            SPECIAL:   state_d = is_special ? PACK : NORM_A;
`ifdef FPMUL_DAZ_EN
            NORM_A:    state_d = NORM_B;
            NORM_B:    state_d = MULTIPLY;
`else
            NORM_A:    if (op_a.m[MAN_W]) state_d = NORM_B;
            NORM_B:    if (op_b.m[MAN_W]) state_d = MULTIPLY;
`endif
            MULTIPLY:  state_d = NORMALIZE;
            NORMALIZE: state_d = DENORM;
`ifdef FPMUL_DAZ_EN
            DENORM:    state_d = ROUND;
`else
            DENORM:    if (!(exp_q < EMIN)) state_d = ROUND;
`endif
            ROUND:     state_d = PACK;
            PACK:      state_d = DONE;
            DONE:      if (out_valid_o && out_ready_i) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // out_valid rises one cycle after DONE is entered and falls on the transfer edge.
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state == DONE) && (state_d == DONE);
    end

    always_comb begin
        is_special = op_a.nan | op_b.nan | op_a.inf | op_b.inf | op_a.zero | op_b.zero;
        spec_nv_d  = 1'b0;
        spec_z_d   = {sign_q, {(W-1){1'b0}}};
        if (op_a.nan | op_b.nan) begin
            spec_z_d  = QNAN;
            spec_nv_d = op_a.snan | op_b.snan;
        end else if ((op_a.inf & op_b.zero) | (op_a.zero & op_b.inf)) begin
            spec_z_d  = QNAN;
            spec_nv_d = 1'b1;
        end else if (op_a.inf | op_b.inf) begin
            spec_z_d  = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    always_comb begin
        pn     = prod_q[PW-1] ? prod_q : {prod_q[PW-2:0], 1'b0};
        e_norm = prod_q[PW-1] ? exp_q + ONE : exp_q;
    end

    always_comb begin
        case (req_q.rm)
            2'b00:   inc_d = grd_q & (rnd_q | stk_q | mant_q[0]);
            2'b01:   inc_d = 1'b0;
            2'b10:   inc_d = sign_q & (grd_q | rnd_q | stk_q);
            default: inc_d = ~sign_q & (grd_q | rnd_q | stk_q);
        endcase
        sum = {1'b0, mant_q} + {{(MAN_W+1){1'b0}}, inc_d};
    end

    always_comb begin
        ovf     = exp_q > BIAS;
        ovf_inf = (req_q.rm == 2'b00) | ((req_q.rm == 2'b11) & ~sign_q) |
                  ((req_q.rm == 2'b10) & sign_q);
        // Hidden bit clear means subnormal or zero; a carry into it packs as the minimum normal.
        efield  = mant_q[MAN_W] ? EXP_W'(exp_q + BIAS) : '0;
        z_d     = {sign_q, efield, mant_q[MAN_W-1:0]};
        flags_d = {2'b00, tiny_q & nx_q, nx_q};
        if (spec_q) begin
            z_d     = spec_z;
            flags_d = {spec_nv, 3'b000};
        end
`ifdef FPMUL_DAZ_EN
        else if (tiny_q) begin
            z_d     = {sign_q, {(W-1){1'b0}}};
            flags_d = 4'b0011;
        end
`endif
        else if (ovf) begin
            z_d     = ovf_inf ? {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                              : {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            flags_d = 4'b0101;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_ni) begin
            in_ready_o  <= 1'b0;
            out_valid_o <= 1'b0;
            z_value_o   <= '0;
            flags_o     <= '0;
            req_q       <= '0;
            op_a        <= '0;
            op_b        <= '0;
            ea_q        <= '0;
            eb_q        <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            prod_q      <= '0;
            mant_q      <= '0;
            grd_q       <= 1'b0;
            rnd_q       <= 1'b0;
            stk_q       <= 1'b0;
            tiny_q      <= 1'b0;
            nx_q        <= 1'b0;
            spec_q      <= 1'b0;
            spec_nv     <= 1'b0;
            spec_z      <= '0;
        end else begin
            in_ready_o  <= in_ready_d;
            out_valid_o <= out_valid_d;
            case (state)
                IDLE: if (in_valid_i && in_ready_o) begin
                    req_q.a  <= a_value_i;
                    req_q.b  <= b_value_i;
                    req_q.rm <= rm_i;
                end
                UNPACK: begin
                    op_a   <= unpack_op(req_q.a);
                    op_b   <= unpack_op(req_q.b);
                    ea_q   <= unpack_exp(req_q.a);
                    eb_q   <= unpack_exp(req_q.b);
                    sign_q <= req_q.a[W-1] ^ req_q.b[W-1];
                    spec_q <= 1'b0;
                end
                SPECIAL: begin
                    spec_q  <= is_special;
                    spec_z  <= spec_z_d;
                    spec_nv <= spec_nv_d;
                end
`ifndef FPMUL_DAZ_EN
                NORM_A: if (!op_a.m[MAN_W]) begin
                    op_a.m <= op_a.m << 1;
                    ea_q   <= ea_q - ONE;
                end
                NORM_B: if (!op_b.m[MAN_W]) begin
                    op_b.m <= op_b.m << 1;
                    eb_q   <= eb_q - ONE;
                end
`endif
                MULTIPLY: begin
                    prod_q <= PW'(op_a.m) * PW'(op_b.m);
                    exp_q  <= ea_q + eb_q;
                end
                NORMALIZE: begin
                    exp_q  <= e_norm;
                    mant_q <= pn[PW-1:MAN_W+1];
                    grd_q  <= pn[MAN_W];
                    rnd_q  <= pn[MAN_W-1];
                    stk_q  <= |pn[MAN_W-2:0];
                    tiny_q <= e_norm < EMIN;
                end
`ifndef FPMUL_DAZ_EN
                DENORM: if (exp_q < EMIN) begin
                    mant_q <= mant_q >> 1;
                    grd_q  <= mant_q[0];
                    rnd_q  <= grd_q;
                    stk_q  <= stk_q | rnd_q;
                    exp_q  <= exp_q + ONE;
                end
`endif
                ROUND: begin
                    nx_q <= grd_q | rnd_q | stk_q;
                    if (sum[MAN_W+1]) begin
                        mant_q <= sum[MAN_W+1:1];
                        exp_q  <= exp_q + ONE;
                    end else begin
                        mant_q <= sum[MAN_W:0];
                    end
                end
                PACK: begin
                    z_value_o <= z_d;
                    flags_o   <= flags_d;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/fp_multiplier_param.md
Name: fp_multiplier_param

Overview:
Parametrised IEEE-754 binary floating-point multiplier for the FPU. Exponent and mantissa widths are generic; binary32 is the default. Uses valid/ready handshakes on both sides, four selectable rounding modes and sticky-free per-operation exception flags. Multi-cycle state machine with one operation in flight; sits behind the FPU operand mux, alongside the adder and divider.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 23, stored fraction width (hidden bit excluded)

Ports:
clk  in  1  clock
reset_ni  in  1  synchronous active-low reset
a_value_i  in  EXP_W+MAN_W+1  operand A
b_value_i  in  EXP_W+MAN_W+1  operand B
rm_i  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RDN (toward -inf), 11 RUP (toward +inf)
in_valid_i  in  1  operands valid
in_ready_o  out  1  block can accept operands
z_value_o  out  EXP_W+MAN_W+1  product
flags_o  out  4  {NV, OF, UF, NX} for the current result
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts result

Behaviour:
- Reset: one clock and reset; reset_ni is synchronous and active-low. While reset_ni=0 at a clock edge: state->IDLE, out_valid_o=0, z_value_o=0, flags_o=0, in_ready_o=0. Reset mid-operation abandons the operation; no result is emitted.
- in_ready_o=1 only in IDLE. An operation is accepted on an edge with in_valid_i & in_ready_o. a_value_i, b_value_i and rm_i are captured on that edge; later changes are ignored.
- States: IDLE, UNPACK, SPECIAL, NORM_A, NORM_B, MULTIPLY, NORMALIZE, DENORM, ROUND, PACK, DONE.
- SPECIAL decides NaN, inf and zero results, then goes to PACK. Every other case proceeds to NORM_A.
- NORM_A / NORM_B shift a subnormal mantissa left one bit per cycle until the hidden bit is set. Each stays one cycle for a normal operand.
- MULTIPLY forms the full (2*MAN_W+2)-bit product. Exponent is held in EXP_W+2 signed bits.
- NORMALIZE is one cycle: single-bit adjust on the product MSB, then extracts mantissa, guard, round and sticky.
- DENORM shifts right one bit per cycle while exponent < 1-bias. Sticky accumulates all bits shifted out. Exits in one cycle if no shift is needed.
- Latency, counted from the accepting edge:
  - normal operands with a normal result: out_valid_o rises 10 cycles later;
  - special cases: 4 cycles later;
  - subnormal inputs or outputs add one cycle per shift.
- DONE: out_valid_o=1. z_value_o and flags_o hold stable until out_ready_i=1. out_valid_o drops on the edge after the transfer, and the state returns to IDLE.
- Rounding: RNE rounds up iff G&(R|S|lsb). RTZ truncates. RDN rounds up magnitude iff sign=1 and (G|R|S). RUP rounds up magnitude iff sign=0 and (G|R|S). Mantissa carry-out increments the exponent.
- Special results:
  - any NaN input -> canonical qNaN (sign 0, exponent all ones, fraction MSB 1); NV set only if an input is signalling;
  - inf*0 -> canonical qNaN with NV;
  - inf*finite-nonzero -> inf, sign a_s^b_s;
  - zero*finite -> signed zero.
- Overflow (exponent > bias after rounding) sets OF and NX. Result is inf for RNE, and for RUP+ / RDN-. Result is max finite for RTZ, and for RUP- / RDN+.
- UF: result tiny (tininess detected before rounding) and inexact. NX: any of G, R, S nonzero, or overflow.
- A rounded subnormal that reaches the minimum normal packs as a normal.

Optional Feature:
- FPMUL_DAZ_EN defined:
  - subnormal inputs are treated as signed zero;
  - tiny results are flushed to signed zero with UF and NX set;
  - NORM_A/NORM_B/DENORM never shift, so latency for all finite nonzero operands is fixed at 10 cycles.
- Not defined: full gradual-underflow handling as described in Behaviour.

Test Plan:
- 0x3FC00000 * 0x40000000, RNE, out_ready_i=1 -> 0x40400000, flags 0000, out_valid_o exactly 10 cycles after accept.
- 0x7F800000 * 0x00000000 -> 0x7FC00000, NV=1, out_valid_o 4 cycles after accept. 0x7F800001 * 0x3F800000 -> 0x7FC00000, NV=1.
- 0x7F000000 * 0x7F000000 -> RNE: 0x7F800000, OF=NX=1. RTZ: 0x7F7FFFFF. RDN with A=0xFF000000: 0xFF800000.
- 0x3F800001 * 0x3F800001 -> RNE 0x3F800002, RUP 0x3F800003, RTZ 0x3F800002, NX=1.
- 0x00800000 * 0x3F000000 -> 0x00400000, flags 0000. With FPMUL_DAZ_EN -> 0x00000000, UF=NX=1.
- Hold out_ready_i=0 for 5 cycles after out_valid_o rises -> z_value_o/flags_o stable, in_ready_o=0. Assert reset_ni=0 for one cycle during MULTIPLY -> out_valid_o stays 0, next accept produces a correct result.
